exec_hazard_controller: RTL and testbench

EXEC_HAZARD_CONTROLLER -- requirements
Module: exec_hazard_controller

---
 rtl/exec_hazard_controller_if.sv | 42 ++++
 rtl/exec_hazard_controller.sv | 137 +++++++++++++
 tb/tb_exec_hazard_controller.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/exec_hazard_controller_if.sv
// Pipeline-side signal bundle for exec_hazard_controller: stage register
// fields in, stall/flush/forward controls and event counters out.
interface exec_hazard_controller_if;
  logic [4:0] IDRn;
  logic [4:0] IDRm;
  logic       IDUsesRn;
  logic       IDUsesRm;
  logic [4:0] EXRn;
  logic [4:0] EXRm;
  logic [4:0] EXRd;
  logic       EXRegWrite;
  logic       EXMemRead;
  logic [4:0] MEMRd;
  logic       MEMRegWrite;
  logic [4:0] WBRd;
  logic       WBRegWrite;
  logic       PCSrc;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IDEXBubble;
  logic       IFIDFlush;
  logic       IDEXFlush;
  logic       EXMEMFlush;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic [7:0] StallCount;
  logic [7:0] FlushCount;

  modport master (
    output IDRn, IDRm, IDUsesRn, IDUsesRm, EXRn, EXRm, EXRd, EXRegWrite, EXMemRead,
           MEMRd, MEMRegWrite, WBRd, WBRegWrite, PCSrc,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, EXMEMFlush,
           ForwardA, ForwardB, StallCount, FlushCount
  );

  modport slave (
    input  IDRn, IDRm, IDUsesRn, IDUsesRm, EXRn, EXRm, EXRd, EXRegWrite, EXMemRead,
           MEMRd, MEMRegWrite, WBRd, WBRegWrite, PCSrc,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, EXMEMFlush,
           ForwardA, ForwardB, StallCount, FlushCount
  );
endinterface

// File: rtl/exec_hazard_controller.sv
// Execute-stage hazard controller: RAW stall detection, branch flush, operand
// forwarding and saturating stall/flush counters. Forwarding via EXEC_FORWARD_EN.
module exec_hazard_controller (
  input  logic                      clk,
  input  logic                      reset,
  exec_hazard_controller_if.slave   hz
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] XZR = 5'd31;

  state_t     state_r;
  state_t     state_next_s;
  logic       hazard_s;
  logic       idex_bubble_s;
  logic [7:0] stall_count_r;
  logic [7:0] flush_count_r;

  // Source hit against one writer; XZR reads are constant and never wait.
  function automatic logic src_hit(input logic uses, input logic [4:0] src,
                                   input logic wr, input logic [4:0] rd);
    return uses & wr & (src != XZR) & (src == rd);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

`ifdef EXEC_FORWARD_EN
  // Memory stage holds the younger result, so it is checked first.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (hz.MEMRegWrite && (hz.MEMRd == src) && (src != XZR)) begin
      return 2'b10;
    end else if (hz.WBRegWrite && (hz.WBRd == src) && (src != XZR)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Only a load in EX cannot be forwarded in time.
  always_comb begin
    hazard_s = hz.EXMemRead &
               (src_hit(hz.IDUsesRn, hz.IDRn, hz.EXRegWrite, hz.EXRd) |
                src_hit(hz.IDUsesRm, hz.IDRm, hz.EXRegWrite, hz.EXRd));
  end
`else
  // Any writer still in EX or MEM must reach WB before the read can proceed.
  always_comb begin
    hazard_s = src_hit(hz.IDUsesRn, hz.IDRn, hz.EXRegWrite,  hz.EXRd)  |
               src_hit(hz.IDUsesRm, hz.IDRm, hz.EXRegWrite,  hz.EXRd)  |
               src_hit(hz.IDUsesRn, hz.IDRn, hz.MEMRegWrite, hz.MEMRd) |
               src_hit(hz.IDUsesRm, hz.IDRm, hz.MEMRegWrite, hz.MEMRd);
  end

  logic unused_fwd_s;
  assign unused_fwd_s = ^{hz.EXRn, hz.EXRm, hz.EXMemRead, hz.WBRd, hz.WBRegWrite};
`endif

  // Next state and pipeline controls; reset overrides, then branch, then hazard.
  always_comb begin
    state_next_s  = state_r;
    hz.PCWrite    = 1'b1;
    hz.IFIDWrite  = 1'b1;
    idex_bubble_s = 1'b0;
    hz.IFIDFlush  = 1'b0;
    hz.IDEXFlush  = 1'b0;
    hz.EXMEMFlush = 1'b0;
    hz.ForwardA   = 2'b00;
    hz.ForwardB   = 2'b00;
    if (reset) begin
      state_next_s  = RUN;
      hz.PCWrite    = 1'b0;
      hz.IFIDWrite  = 1'b0;
      hz.IFIDFlush  = 1'b1;
      hz.IDEXFlush  = 1'b1;
      hz.EXMEMFlush = 1'b1;
    end else begin
`ifdef EXEC_FORWARD_EN
      hz.ForwardA = fwd_sel(hz.EXRn);
      hz.ForwardB = fwd_sel(hz.EXRm);
`endif
      if (hz.PCSrc) begin
        state_next_s  = FLUSH;
        hz.IFIDFlush  = 1'b1;
        hz.IDEXFlush  = 1'b1;
        hz.EXMEMFlush = 1'b1;
      end else begin
        case (state_r)
          RUN, STALL: begin
            if (hazard_s) begin
              state_next_s  = STALL;
              hz.PCWrite    = 1'b0;
              hz.IFIDWrite  = 1'b0;
              idex_bubble_s = 1'b1;
            end else begin
              state_next_s  = RUN;
            end
          end
          FLUSH:   state_next_s = RUN;
          default: state_next_s = RUN;
        endcase
      end
    end
  end

  assign hz.IDEXBubble = idex_bubble_s;
  assign hz.StallCount = stall_count_r;
  assign hz.FlushCount = flush_count_r;

  // State register and saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= RUN;
      stall_count_r <= 8'd0;
      flush_count_r <= 8'd0;
    end else begin
      state_r <= state_next_s;
      if (idex_bubble_s) begin
        stall_count_r <= sat_inc(stall_count_r);
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (hz.PCSrc) begin
        flush_count_r <= sat_inc(flush_count_r);
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

endmodule

// File: tb/tb_exec_hazard_controller.sv
// Directed bench for exec_hazard_controller; covers the build selected by EXEC_FORWARD_EN.
module tb_exec_hazard_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;

  exec_hazard_controller_if hz ();

  exec_hazard_controller dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, EXMEMFlush}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {2'b00, hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble,
              hz.IFIDFlush, hz.IDEXFlush, hz.EXMEMFlush}, {2'b00, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.IDRn = 5'd0; hz.IDRm = 5'd0; hz.IDUsesRn = 1'b0; hz.IDUsesRm = 1'b0;
    hz.EXRn = 5'd0; hz.EXRm = 5'd0; hz.EXRd = 5'd0;
    hz.EXRegWrite = 1'b0; hz.EXMemRead = 1'b0;
    hz.MEMRd = 5'd0; hz.MEMRegWrite = 1'b0;
    hz.WBRd = 5'd0; hz.WBRegWrite = 1'b0; hz.PCSrc = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    #1;
    chk_ctl("reset_ctl", 6'b000111);
    tick();
    tick();
    chk("reset_stall", hz.StallCount, 8'd0);
    chk("reset_flush", hz.FlushCount, 8'd0);

    reset = 1'b0;
    #1;
    chk_ctl("idle_ctl", 6'b110000);
    tick();

`ifdef EXEC_FORWARD_EN
    // Load-use: exactly one bubble, then forwarding covers the rest.
    hz.EXMemRead = 1'b1; hz.EXRegWrite = 1'b1; hz.EXRd = 5'd3;
    hz.IDRn = 5'd3; hz.IDUsesRn = 1'b1;
    #1;
    chk_ctl("loaduse_ctl", 6'b001000);
    tick();
    exp_stall = 1;
    chk("loaduse_cnt", hz.StallCount, 8'(exp_stall));
    hz.EXMemRead = 1'b0; hz.EXRegWrite = 1'b0; hz.EXRd = 5'd0;
    hz.MEMRegWrite = 1'b1; hz.MEMRd = 5'd3;
    #1;
    chk_ctl("loaduse_moved", 6'b110000);
    tick();
    chk("loaduse_cnt2", hz.StallCount, 8'(exp_stall));

    clear_in();
    hz.EXRegWrite = 1'b1; hz.EXRd = 5'd6; hz.IDRn = 5'd6; hz.IDUsesRn = 1'b1;
    #1;
    chk_ctl("alu_nostall", 6'b110000);

    clear_in();
    hz.MEMRegWrite = 1'b1; hz.MEMRd = 5'd5; hz.WBRegWrite = 1'b1; hz.WBRd = 5'd5;
    hz.EXRn = 5'd5; hz.EXRm = 5'd5;
    #1;
    chk("fwdA_mem", {6'd0, hz.ForwardA}, 8'd2);
    chk("fwdB_mem", {6'd0, hz.ForwardB}, 8'd2);
    hz.MEMRegWrite = 1'b0;
    #1;
    chk("fwdA_wb", {6'd0, hz.ForwardA}, 8'd1);
    hz.EXRm = 5'd9;
    #1;
    chk("fwdB_none", {6'd0, hz.ForwardB}, 8'd0);
    tick();
`else
    // Writer passes EX then MEM: two stall cycles, none once it reaches WB.
    hz.EXRegWrite = 1'b1; hz.EXRd = 5'd7; hz.IDRm = 5'd7; hz.IDUsesRm = 1'b1;
    #1;
    chk_ctl("raw_ex_ctl", 6'b001000);
    tick();
    chk("raw_ex_cnt", hz.StallCount, 8'd1);
    hz.EXRegWrite = 1'b0; hz.EXRd = 5'd0; hz.MEMRegWrite = 1'b1; hz.MEMRd = 5'd7;
    hz.EXRn = 5'd7;
    #1;
    chk_ctl("raw_mem_ctl", 6'b001000);
    chk("nofwd_A", {6'd0, hz.ForwardA}, 8'd0);
    tick();
    chk("raw_mem_cnt", hz.StallCount, 8'd2);
    hz.MEMRegWrite = 1'b0; hz.MEMRd = 5'd0; hz.WBRegWrite = 1'b1; hz.WBRd = 5'd7;
    #1;
    chk_ctl("raw_wb_ctl", 6'b110000);
    tick();
    exp_stall = 2;
    chk("raw_wb_cnt", hz.StallCount, 8'(exp_stall));

    clear_in();
    hz.EXRegWrite = 1'b1; hz.EXRd = 5'd4; hz.IDRn = 5'd4; hz.IDUsesRn = 1'b0;
    #1;
    chk_ctl("unused_src", 6'b110000);
`endif

    // XZR never stalls or forwards.
    clear_in();
    hz.EXMemRead = 1'b1; hz.EXRegWrite = 1'b1; hz.EXRd = 5'd31;
    hz.IDRn = 5'd31; hz.IDUsesRn = 1'b1;
    hz.MEMRegWrite = 1'b1; hz.MEMRd = 5'd31; hz.IDRm = 5'd31; hz.IDUsesRm = 1'b1;
    hz.EXRn = 5'd31;
    #1;
    chk_ctl("xzr_ctl", 6'b110000);
    chk("xzr_fwdA", {6'd0, hz.ForwardA}, 8'd0);
    tick();
    chk("xzr_cnt", hz.StallCount, 8'(exp_stall));

    // Branch beats load-use hazard, then one FLUSH cycle, then RUN.
    clear_in();
    hz.EXMemRead = 1'b1; hz.EXRegWrite = 1'b1; hz.EXRd = 5'd3;
    hz.IDRn = 5'd3; hz.IDUsesRn = 1'b1; hz.PCSrc = 1'b1;
    #1;
    chk_ctl("br_ctl", 6'b110111);
    tick();
    chk("br_flushcnt", hz.FlushCount, 8'd1);
    chk("br_stallcnt", hz.StallCount, 8'(exp_stall));
    hz.PCSrc = 1'b0;
    #1;
    chk_ctl("flush_state_ctl", 6'b110000);
    tick();
    chk("flush_state_cnt", hz.StallCount, 8'(exp_stall));
    chk_ctl("after_flush_run", 6'b001000);
    tick();
    exp_stall++;
    chk("after_flush_cnt", hz.StallCount, 8'(exp_stall));

    // Hold the stall long enough to saturate.
    for (int i = 0; i < 260; i++) tick();
    chk("sat_cnt", hz.StallCount, 8'd255);
    chk_ctl("sat_ctl", 6'b001000);

    // Reset in the middle of STALL.
    reset = 1'b1;
    #1;
    chk_ctl("rst_stall_ctl", 6'b000111);
    chk("rst_fwd", {6'd0, hz.ForwardA}, 8'd0);
    tick();
    chk("rst_stall_cnt", hz.StallCount, 8'd0);
    chk("rst_flush_cnt", hz.FlushCount, 8'd0);
    reset = 1'b0;
    clear_in();
    #1;
    chk_ctl("rst_release_ctl", 6'b110000);
    tick();
    chk("rst_release_cnt", hz.StallCount, 8'd0);

    // Reset in the middle of FLUSH leaves nothing behind.
    hz.PCSrc = 1'b1;
    tick();
    hz.PCSrc = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_ctl("rst_flush_ctl", 6'b110000);
    chk("rst_flush_cnt2", hz.FlushCount, 8'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
